// File: rtl/apb_textbuf_pkg.sv
// Shared constants and types for the APB text-buffer writer: register map, cursor fields,
// screen geometry defaults and the sweep FSM states.
package apb_textbuf_pkg;

    localparam int unsigned DEF_COLS      = 80;
    localparam int unsigned DEF_ROWS      = 30;
    localparam logic [7:0]  DEF_FILL_CHAR = 8'h20;

    localparam logic [7:0]  NEWLINE = 8'h0A;

    // Word index (paddr[3:2]) of each register
    localparam logic [1:0] REG_CHAR   = 2'd0;
    localparam logic [1:0] REG_CURSOR = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned COL_LSB = 0;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned ROW_LSB = 8;
    localparam int unsigned ROW_W   = 5;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

endpackage

// File: rtl/textbuf_cursor.sv
// Row/column cursor with advance, newline, load and home, plus its linear buffer address.
module textbuf_cursor
    import apb_textbuf_pkg::*;
#(
    parameter int unsigned COLS   = DEF_COLS,
    parameter int unsigned ROWS   = DEF_ROWS,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_home,
    input  logic              i_load,
    input  logic [COL_W-1:0]  i_col,
    input  logic [ROW_W-1:0]  i_row,
    input  logic              i_inc,
    input  logic              i_newline,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  w_col_d;
    logic [ROW_W-1:0]  w_row_d;
    logic [ROW_W-1:0]  w_row_next;
    logic [ADDR_W-1:0] w_row_base;

    assign w_row_next = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;

    always_comb begin
        w_col_d = r_col;
        w_row_d = r_row;
        if (i_home) begin
            w_col_d = '0;
            w_row_d = '0;
        end else if (i_load) begin
            w_col_d = i_col;
            w_row_d = i_row;
        end else if (i_newline) begin
            w_col_d = '0;
            w_row_d = w_row_next;
        end else if (i_inc) begin
            if (r_col == COL_LAST) begin
                w_col_d = '0;
                w_row_d = w_row_next;
            end else begin
                w_col_d = r_col + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_col <= w_col_d;
            r_row <= w_row_d;
        end
    end

    // 80 columns: row*80 = row*64 + row*16, avoiding a multiplier
    if (COLS == 80) begin : g_shift
        assign w_row_base = (ADDR_W'(r_row) << 6) + (ADDR_W'(r_row) << 4);
    end else begin : g_mult
        assign w_row_base = ADDR_W'(32'(r_row) * COLS);
    end

    assign o_addr = w_row_base + ADDR_W'(r_col);
    assign o_col  = r_col;
    assign o_row  = r_row;

endmodule

// File: rtl/apb_textbuf_writer.sv
// APB3 slave driving a text buffer write port: character writes at a cursor, newline handling
// and a hardware clear-screen sweep.
module apb_textbuf_writer
    import apb_textbuf_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned ADDR_W    = 12,
    parameter logic [7:0]  FILL_CHAR = DEF_FILL_CHAR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [3:0]        paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [7:0]        char_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wen_o
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(COLS * ROWS - 1);

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_d;

    logic              r_wen;
    logic [7:0]        r_char;
    logic [ADDR_W-1:0] r_addr;
    logic              w_wen_d;
    logic [7:0]        w_char_d;
    logic [ADDR_W-1:0] w_addr_d;

    logic              w_access;
    logic [1:0]        w_idx;
    logic              w_busy;
    logic              w_stall;
    logic              w_wr;
    logic              w_cur_ok;
    logic              w_char_wr;
    logic              w_is_nl;
    logic              w_cur_wr;
    logic              w_clr_go;
    logic              w_home;
    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_unused;

    assign w_access = psel_i & penable_i;
    assign w_idx    = paddr_i[3:2];
    assign w_busy   = (r_state == CLEAR);
    // Writes that could disturb the cursor or restart a sweep wait out the current sweep
    assign w_stall  = w_busy & pwrite_i & (w_idx != REG_STATUS);
    assign w_wr     = w_access & pwrite_i & ~w_stall;

    assign w_cur_ok  = (32'(pwdata_i[COL_LSB +: COL_W]) < COLS)
                     && (32'(pwdata_i[ROW_LSB +: ROW_W]) < ROWS);
    assign w_is_nl   = (pwdata_i[7:0] == NEWLINE);
    assign w_char_wr = w_wr & (w_idx == REG_CHAR);
    assign w_cur_wr  = w_wr & (w_idx == REG_CURSOR) & w_cur_ok;
    assign w_clr_go  = w_wr & (w_idx == REG_CTRL) & pwdata_i[0];

    assign pready_o  = ~w_stall;
    assign pslverr_o = w_wr & (((w_idx == REG_CURSOR) & ~w_cur_ok) | (w_idx == REG_STATUS));

    always_comb begin
        prdata_o = '0;
        if (w_access && !pwrite_i) begin
            unique case (w_idx)
                REG_CURSOR: prdata_o = {19'b0, w_row, 1'b0, w_col};
                REG_STATUS: prdata_o = {31'b0, w_busy};
                default:    prdata_o = '0;
            endcase
        end
    end

    textbuf_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_home    (w_home),
        .i_load    (w_cur_wr),
        .i_col     (pwdata_i[COL_LSB +: COL_W]),
        .i_row     (pwdata_i[ROW_LSB +: ROW_W]),
        .i_inc     (w_char_wr & ~w_is_nl),
        .i_newline (w_char_wr & w_is_nl),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_addr    (w_cur_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_clr_go) begin
                    w_state_d = CLEAR;
                    w_cnt_d   = '0;
                end
            end
            CLEAR: begin
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_wen_d  = 1'b0;
        w_char_d = r_char;
        w_addr_d = r_addr;
        w_home   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_char_wr && !w_is_nl) begin
                    w_wen_d  = 1'b1;
                    w_char_d = pwdata_i[7:0];
                    w_addr_d = w_cur_addr;
                end
            end
            CLEAR: begin
                w_wen_d  = 1'b1;
                w_char_d = FILL_CHAR;
                w_addr_d = r_cnt;
                w_home   = (r_cnt == CNT_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen  <= 1'b0;
            r_char <= '0;
            r_addr <= '0;
        end else begin
            r_wen  <= w_wen_d;
            r_char <= w_char_d;
            r_addr <= w_addr_d;
        end
    end

    assign wen_o  = r_wen;
    assign char_o = r_char;
    assign addr_o = r_addr;

    assign w_unused = ^{pwdata_i[31:13], paddr_i[1:0]};

endmodule

// File: tb/tb_apb_textbuf_writer.sv
// Self-checking bench for apb_textbuf_writer: expected buffer writes go to a scoreboard queue
// and are popped as wen_o pulses appear.
module tb_apb_textbuf_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [3:0]  paddr_i = '0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic [7:0]  char_o;
    logic [11:0] addr_o;
    logic        wen_o;

    int checks = 0;
    int errors = 0;
    int n_pops = 0;
    logic [19:0] sb[$];

    apb_textbuf_writer dut (
        .clk       (clk),
        .rst       (rst),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .paddr_i   (paddr_i),
        .pwdata_i  (pwdata_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .char_o    (char_o),
        .addr_o    (addr_o),
        .wen_o     (wen_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every buffer write must match the oldest expected entry
    always @(negedge clk) begin
        if (wen_o === 1'b1) begin
            logic [19:0] exp_w;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_wen got addr %0d char %h exp no write", addr_o, char_o);
            end else begin
                exp_w = sb.pop_front();
                n_pops++;
                if ({addr_o, char_o} !== exp_w) begin
                    errors++;
                    $display("FAIL sb_write got addr %0d char %h exp addr %0d char %h",
                             addr_o, char_o, exp_w[19:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d,
                             output logic err, output int waits);
        @(posedge clk); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
        @(posedge clk); #1;
        penable_i = 1'b1;
        waits = 0;
        @(negedge clk);
        while (pready_o !== 1'b1 && waits < 5000) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 5000) begin
            checks++;
            errors++;
            $display("FAIL write_timeout got pready %b exp 1", pready_o);
        end
        err = pslverr_o;
        @(posedge clk); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
        @(posedge clk); #1;
        penable_i = 1'b1;
        @(negedge clk);
        checks++;
        if (pready_o !== 1'b1) begin
            errors++;
            $display("FAIL read_pready got %b exp 1", pready_o);
        end
        d = prdata_o;
        @(posedge clk); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #2;
        checks++;
        if ({wen_o, char_o, addr_o} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got wen %b char %h addr %0d exp 0 0 0",
                     wen_o, char_o, addr_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        apb_read(4'h4, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_cursor got %h exp 00000000", d);
        end
        apb_read(4'hC, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status got %h exp 00000000", d);
        end
    endtask

    task automatic test_char();
        logic err; int w; logic [31:0] d;
        sb.push_back({12'd0, 8'h41});
        apb_write(4'h0, 32'h41, err, w);
        checks++;
        if (wen_o !== 1'b1) begin
            errors++;
            $display("FAIL char_wen_latency got %b exp 1", wen_o);
        end
        apb_read(4'h4, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL char_cursor got %h exp 00000001", d);
        end
    endtask

    task automatic test_wrap();
        logic err; int w; logic [31:0] d;
        apb_write(4'h4, (32'd29 << 8) | 32'd79, err, w);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cursor_err got %b exp 0", err);
        end
        sb.push_back({12'd2399, 8'h42});
        apb_write(4'h0, 32'h42, err, w);
        apb_read(4'h4, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL wrap_cursor got %h exp 00000000", d);
        end
    endtask

    task automatic test_newline();
        logic err; int w; logic [31:0] d;
        apb_write(4'h4, (32'd3 << 8) | 32'd10, err, w);
        apb_write(4'h0, 32'h0A, err, w);
        apb_read(4'h4, d);
        checks++;
        if (d !== 32'h400) begin
            errors++;
            $display("FAIL newline_cursor got %h exp 00000400", d);
        end
        sb.push_back({12'd320, 8'h43});
        apb_write(4'h0, 32'h43, err, w);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL newline_drain got %0d pending exp 0", sb.size());
        end
    endtask

    task automatic test_errors();
        logic err; int w; logic [31:0] d;
        apb_write(4'h4, (32'd5 << 8) | 32'd7, err, w);
        apb_write(4'h4, (32'd5 << 8) | 32'd80, err, w);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_col80 got %b exp 1", err);
        end
        apb_write(4'h4, (32'd30 << 8), err, w);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_row30 got %b exp 1", err);
        end
        apb_read(4'h5, d);
        checks++;
        if (d !== 32'h507) begin
            errors++;
            $display("FAIL err_cursor_kept got %h exp 00000507", d);
        end
        apb_write(4'hC, 32'h1, err, w);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_status_write got %b exp 1", err);
        end
        apb_read(4'hC, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL err_status_after got %h exp 00000000", d);
        end
        apb_read(4'h0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL err_char_read got %h exp 00000000", d);
        end
    endtask

    task automatic test_clear();
        logic err; int w; logic [31:0] d;
        for (int i = 0; i < 2400; i++) sb.push_back({12'(i), 8'h20});
        sb.push_back({12'd0, 8'h44});
        apb_write(4'h8, 32'h1, err, w);
        apb_read(4'hC, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL clear_busy got %h exp 00000001", d);
        end
        apb_write(4'h0, 32'h44, err, w);
        checks++;
        if (w < 2000) begin
            errors++;
            $display("FAIL clear_stall got %0d wait cycles exp >= 2000", w);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL clear_drain got %0d pending exp 0", sb.size());
        end
        apb_read(4'h4, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL clear_cursor got %h exp 00000001", d);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic err; int w; int n; logic [31:0] d;
        for (int i = 0; i < 2400; i++) sb.push_back({12'(i), 8'h20});
        n_pops = 0;
        apb_write(4'h8, 32'h1, err, w);
        n = 0;
        while (n_pops < 1000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n_pops != 1000) begin
            errors++;
            $display("FAIL rst_reach_1000 got %0d pulses exp 1000", n_pops);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (wen_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_wen got %b exp 0", wen_o);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        apb_read(4'hC, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_status got %h exp 00000000", d);
        end
        apb_read(4'h4, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_cursor got %h exp 00000000", d);
        end
    endtask

    initial begin
        test_reset();
        test_char();
        test_wrap();
        test_newline();
        test_errors();
        test_clear();
        test_reset_mid_sweep();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
